// File: rtl/ram_access_arbiter.sv
// Two-requester single-port-style RAM arbiter with an optional zero-fill after reset.
// One RAM access per cycle; read data returns one cycle after the grant.
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | writing zero to every RAM word, requesters held off
// RUN   | alternating-priority arbitration between m0 and m1
module ram_access_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    output logic                  busy,

    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_req_we,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [DATA_WIDTH-1:0] m0_req_wrdata,
    output logic                  m0_resp_valid,
    output logic [DATA_WIDTH-1:0] m0_resp_rddata,

    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_req_we,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [DATA_WIDTH-1:0] m1_req_wrdata,
    output logic                  m1_resp_valid,
    output logic [DATA_WIDTH-1:0] m1_resp_rddata,

    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rddata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wrdata
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  prio;       // 0: m0 wins a tie, 1: m1 wins a tie
    logic                  grant0;
    logic                  grant1;
    logic                  resp0_q;
    logic                  resp1_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_cnt <= '0;
            prio    <= 1'b0;
            resp0_q <= 1'b0;
            resp1_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + CNT_ONE;
            end
            // The loser of a grant gets the next tie.
            if (grant0) begin
                prio <= 1'b1;
            end else if (grant1) begin
                prio <= 1'b0;
            end
            resp0_q <= grant0 & ~m0_req_we;
            resp1_q <= grant1 & ~m1_req_we;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        grant0      = 1'b0;
        grant1      = 1'b0;
        ram_we      = 1'b0;
        ram_rd_addr = m0_req_addr;
        ram_wr_addr = m0_req_addr;
        ram_wrdata  = m0_req_wrdata;
        case (state)
            CLEAR: begin
                busy        = 1'b1;
                ram_we      = 1'b1;
                ram_wr_addr = clr_cnt;
                ram_wrdata  = '0;
                if (clr_cnt == {ADDR_WIDTH{1'b1}}) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                grant0 = m0_req_valid & (~m1_req_valid | ~prio);
                grant1 = m1_req_valid & (~m0_req_valid | prio);
                if (grant1) begin
                    ram_we      = m1_req_we;
                    ram_rd_addr = m1_req_addr;
                    ram_wr_addr = m1_req_addr;
                    ram_wrdata  = m1_req_wrdata;
                end else if (grant0) begin
                    ram_we = m0_req_we;
                end
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    assign m0_req_ready   = grant0;
    assign m1_req_ready   = grant1;
    assign m0_resp_valid  = resp0_q;
    assign m1_resp_valid  = resp1_q;
    assign m0_resp_rddata = ram_rddata;
    assign m1_resp_rddata = ram_rddata;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: a word-level RAM/arbitration model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ram_access_arbiter;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          req_v    [2];
    logic          req_we   [2];
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] req_data [2];

    logic          busy, rdy0, rdy1, rv0, rv1;
    logic [DW-1:0] rd0, rd1;
    logic [AW-1:0] ram_rd_addr, ram_wr_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wrdata, ram_rddata;
    logic [DW-1:0] ram_mem [DEPTH];

    // CLEAR_ON_RESET=0 instance, only m0 used
    logic          nc_v0, nc_we0;
    logic [AW-1:0] nc_addr0;
    logic [DW-1:0] nc_data0;
    logic          nc_zero_v = 1'b0;
    logic [AW-1:0] nc_zero_a = '0;
    logic [DW-1:0] nc_zero_d = '0;
    logic          nc_busy, nc_rdy0, nc_rdy1, nc_rv0, nc_rv1, nc_we;
    logic [DW-1:0] nc_rd0, nc_rd1, nc_wrdata;
    logic [AW-1:0] nc_rd_addr, nc_wr_addr;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_wr_addr] <= ram_wrdata;
        ram_rddata <= ram_mem[ram_rd_addr];
    end

    ram_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rstn(rstn), .busy(busy),
        .m0_req_valid(req_v[0]), .m0_req_ready(rdy0), .m0_req_we(req_we[0]),
        .m0_req_addr(req_addr[0]), .m0_req_wrdata(req_data[0]),
        .m0_resp_valid(rv0), .m0_resp_rddata(rd0),
        .m1_req_valid(req_v[1]), .m1_req_ready(rdy1), .m1_req_we(req_we[1]),
        .m1_req_addr(req_addr[1]), .m1_req_wrdata(req_data[1]),
        .m1_resp_valid(rv1), .m1_resp_rddata(rd1),
        .ram_rd_addr(ram_rd_addr), .ram_rddata(ram_rddata), .ram_we(ram_we),
        .ram_wr_addr(ram_wr_addr), .ram_wrdata(ram_wrdata)
    );

    ram_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b0)) dut_nc (
        .clk(clk), .rstn(rstn), .busy(nc_busy),
        .m0_req_valid(nc_v0), .m0_req_ready(nc_rdy0), .m0_req_we(nc_we0),
        .m0_req_addr(nc_addr0), .m0_req_wrdata(nc_data0),
        .m0_resp_valid(nc_rv0), .m0_resp_rddata(nc_rd0),
        .m1_req_valid(nc_zero_v), .m1_req_ready(nc_rdy1), .m1_req_we(nc_zero_v),
        .m1_req_addr(nc_zero_a), .m1_req_wrdata(nc_zero_d),
        .m1_resp_valid(nc_rv1), .m1_resp_rddata(nc_rd1),
        .ram_rd_addr(nc_rd_addr), .ram_rddata(nc_zero_d), .ram_we(nc_we),
        .ram_wr_addr(nc_wr_addr), .ram_wrdata(nc_wrdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: memory contents, clear progress, tie owner, responses due.
    bit            chk_en     = 1'b0;
    bit            m_clr      = 1'b1;
    int            m_clr_addr = 0;
    int            m_ptr      = 0;
    bit            m_pend  [2];
    logic [DW-1:0] m_pdata [2];
    logic [DW-1:0] m_mem   [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_pend[0] = 1'b0;
        m_pend[1] = 1'b0;
    end

    always @(negedge clk) begin
        int w;
        w = -1;
        if (!m_clr) begin
            if (req_v[0] && req_v[1]) w = m_ptr;
            else if (req_v[0])        w = 0;
            else if (req_v[1])        w = 1;
        end
        if (chk_en) begin
            if (m_clr) begin
                chk("clr_busy", busy, 1);
                chk("clr_ready", {rdy1, rdy0}, 0);
                chk("clr_we", ram_we, 1);
                chk("clr_addr", ram_wr_addr, m_clr_addr);
                chk("clr_data", ram_wrdata, 0);
            end else begin
                chk("run_busy", busy, 0);
                chk("ready", {rdy1, rdy0}, (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00);
                if (w >= 0 && req_we[w]) begin
                    chk("wr_we", ram_we, 1);
                    chk("wr_addr", ram_wr_addr, req_addr[w]);
                    chk("wr_data", ram_wrdata, req_data[w]);
                end else begin
                    chk("idle_we", ram_we, 0);
                end
                if (w >= 0 && !req_we[w]) chk("rd_addr", ram_rd_addr, req_addr[w]);
            end
            chk("resp_valid", {rv1, rv0}, {m_pend[1], m_pend[0]});
            if (m_pend[0]) chk("resp0_data", rd0, m_pdata[0]);
            if (m_pend[1]) chk("resp1_data", rd1, m_pdata[1]);
        end
        if (!rstn) begin
            m_clr = 1'b1; m_clr_addr = 0; m_ptr = 0;
            m_pend[0] = 1'b0; m_pend[1] = 1'b0;
        end else begin
            m_pend[0] = 1'b0; m_pend[1] = 1'b0;
            if (m_clr) begin
                m_mem[m_clr_addr] = '0;
                m_clr_addr++;
                if (m_clr_addr == DEPTH) m_clr = 1'b0;
            end else if (w >= 0) begin
                if (req_we[w]) m_mem[req_addr[w]] = req_data[w];
                else begin
                    m_pend[w]  = 1'b1;
                    m_pdata[w] = m_mem[req_addr[w]];
                end
                m_ptr = 1 - w;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic busy_count(output int c);
        c = 0;
        for (int n = 0; n < 40; n++) begin
            if (!busy) break;
            c++;
            step();
            #1;
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_data[i] = '0;
        end
    endtask

    initial begin
        int  cnt;
        bit  found;
        bit  got [2];
        rstn = 1'b0;
        idle_all();
        nc_v0 = 1'b1; nc_we0 = 1'b1; nc_addr0 = 4'd5; nc_data0 = 16'h1234;
        step();
        chk_en = 1'b1;
        rstn   = 1'b1;
        #1;
        chk("nc_busy", nc_busy, 0);
        chk("nc_first_grant", nc_rdy0, 1);
        chk("nc_we", nc_we, 1);
        chk("nc_wr_addr", nc_wr_addr, 5);
        chk("start_busy", busy, 1);
        chk("start_addr", ram_wr_addr, 0);
        nc_v0 = 1'b0;
        busy_count(cnt);
        chk("clear_len", cnt, 16);

        // write 0xA5 to 3, read it back next cycle
        req_v[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 4'd3; req_data[0] = 16'h00A5;
        step();
        req_we[0] = 1'b0;
        #1;
        chk("raw_rd_grant", rdy0, 1);
        step();
        idle_all();
        #1;
        chk("raw_resp0_valid", rv0, 1);
        chk("raw_resp0_data", rd0, 16'h00A5);
        chk("raw_resp1_quiet", rv1, 0);

        // m1 alone for three cycles, then continuous tie
        step();
        req_v[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 4'd3;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("solo_m1_ready", rdy1, 1);
            chk("solo_m0_ready", rdy0, 0);
            step();
        end
        req_v[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 4'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("tie_m0_grant", rdy0, (k % 2 == 0));
            chk("tie_m1_grant", rdy1, (k % 2 == 1));
            if (k > 0) begin
                chk("tie_resp0", rv0, ((k - 1) % 2 == 0));
                chk("tie_resp1", rv1, ((k - 1) % 2 == 1));
            end
            step();
        end
        idle_all();

        // random traffic, requesters hold until accepted
        got[0] = 1'b1; got[1] = 1'b1;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_v[i] || got[i]) begin
                    req_v[i]    = ($urandom_range(0, 3) != 0);
                    req_we[i]   = 1'($urandom_range(0, 1));
                    req_addr[i] = AW'($urandom_range(0, 7));
                    req_data[i] = DW'($urandom);
                end
            end
            #1;
            got[0] = rdy0;
            got[1] = rdy1;
            step();
        end

        // reset in RUN, then reset again at clear address 7
        idle_all();
        rstn = 1'b0;
        step();
        rstn  = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (busy && ram_wr_addr == 4'd7) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("reach_addr7", found, 1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        #1;
        chk("restart_addr", ram_wr_addr, 0);
        busy_count(cnt);
        chk("restart_len", cnt, 16);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
